// File: rtl/fifo_fwft_out.sv
// First-word-fall-through output stage: turns rd_en/rd_data with fixed RAM latency into a valid/ready stream.
// Optional macro FWFT_CNT_EN adds the fifo_cnt_rd_synced input and the registered occupancy output.
module fifo_fwft_out #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_empty,
    output logic                     rd_en,
    input  logic [DWIDTH-1:0]        rd_data,
    output logic [DWIDTH-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready
`ifdef FWFT_CNT_EN
    ,
    input  logic [$clog2(DEPTH):0]   fifo_cnt_rd_synced,
    output logic [$clog2(DEPTH)+1:0] occupancy
`endif
);

    localparam int unsigned BUF_DEPTH = RD_LAT + 2;
    localparam int unsigned CW        = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW        = $clog2(BUF_DEPTH);

    if (RD_LAT < 1 || RD_LAT > 3 || DEPTH < 1) begin : g_param_check
        $error("fifo_fwft_out: RD_LAT must be 1..3 and DEPTH at least 1");
    end

    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     buf_cnt_q, buf_cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DWIDTH-1:0] mem_d [BUF_DEPTH];
    logic [CW:0]       level;
    logic              cap;
    logic              pop;

    // Non-power-of-two buffer, so wrap is an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request only while every outstanding word is guaranteed a buffer slot.
    assign level   = (CW+1)'(inflight_q) + (CW+1)'(buf_cnt_q);
    assign rd_en   = ~rst & ~rd_empty & (level < (CW+1)'(BUF_DEPTH));
    assign cap     = vld_q[RD_LAT-1];
    assign m_valid = (buf_cnt_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign pop     = m_valid & m_ready;

    always_comb begin
        vld_d      = RD_LAT'({vld_q, rd_en});
        inflight_d = inflight_q + CW'(rd_en) - CW'(cap);
        buf_cnt_d  = buf_cnt_q + CW'(cap) - CW'(pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (cap) begin
            mem_d[wr_ptr_q] = rd_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
            buf_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

`ifdef FWFT_CNT_EN
    localparam int unsigned OW = $clog2(DEPTH) + 2;

    logic [OW-1:0] occupancy_q, occupancy_d;

    // Words in the FIFO plus words already pulled into this stage; one cycle behind its operands.
    always_comb begin
        occupancy_d = OW'(fifo_cnt_rd_synced) + OW'(inflight_q) + OW'(buf_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;
`endif

endmodule

// File: tb/tb_fifo_fwft_out.sv
// Bench for fifo_fwft_out at RD_LAT=3 (five-entry skid buffer): FIFO/RAM model, scoreboard, directed scenarios.
module tb_fifo_fwft_out;

    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 3;
    localparam int unsigned BUFD  = LAT + 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_ready = 1'b0;
    logic          force_empty = 1'b0;
    logic          rd_empty;
    logic          rd_en;
    logic          m_valid;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
`ifdef FWFT_CNT_EN
    logic [$clog2(DEPTH):0]   fifo_cnt = '0;
    logic [$clog2(DEPTH)+1:0] occupancy;
`endif

    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] src [2048];
    int            src_n = 0;
    int            rd_idx = 0;
    int            tb_cnt = 0;
    logic [DW-1:0] pipe [LAT];
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0] cyc = '0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_fwft_out #(.DWIDTH(DW), .RD_LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_empty(rd_empty),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef FWFT_CNT_EN
        ,
        .fifo_cnt_rd_synced(fifo_cnt),
        .occupancy         (occupancy)
`endif
    );

    // FIFO + RAM model: data appears LAT cycles after an accepted read, garbage otherwise.
    assign rd_empty = force_empty | (rd_idx >= src_n);
    assign rd_data  = pipe[LAT-1];

    always @(posedge clk) begin
        pipe[0] <= rd_en ? src[rd_idx] : (32'hDEAD_0000 | cyc);
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        if (rd_en) rd_idx <= rd_idx + 1;
        cyc <= cyc + 32'd1;
        if (rst) begin
            pv     <= '0;
            tb_cnt <= 0;
        end else begin
            pv     <= {pv[LAT-2:0], rd_en};
            tb_cnt <= tb_cnt + (pv[LAT-1] ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        src[src_n] = w;
        src_n++;
        exp_q.push_back(w);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        m_ready     = 1'b1;
        force_empty = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk(nm, exp_q.size(), 0);
        repeat (8) step();
    endtask

    // Monitor: every presented word must be the scoreboard head; protocol checks each cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid_vs_model", int'(m_valid), (tb_cnt != 0) ? 1 : 0);
            chk("buf_no_overflow", (tb_cnt <= int'(BUFD)) ? 1 : 0, 1);
            chk("rd_en_while_empty", int'(rd_en & rd_empty), 0);
            if (m_valid) begin
                chk("word_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                if (exp_q.size() != 0) begin
                    chk("m_data", int'(m_data), int'(exp_q[0]));
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_rd;
        int n_v;
        int first_v;
        int last_v;

        // Reset with a word pending: rd_en must stay low, outputs at reset values.
        load(32'h0000_00A5);
        repeat (2) step();
        @(negedge clk);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_rd_en", int'(rd_en), 0);

        // Single word: rd_en in cycle 0 only, m_valid exactly in cycle LAT+1.
        step();
        rst     = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("lat_rd_en_c0", int'(rd_en), 1);
        chk("lat_m_valid_c0", int'(m_valid), 0);
        step();
        @(negedge clk);
        chk("lat_rd_en_c1", int'(rd_en), 0);
        step();
        step();
        @(negedge clk);
        chk("lat_m_valid_c3", int'(m_valid), 0);
        step();
        @(negedge clk);
        chk("lat_m_valid_c4", int'(m_valid), 1);
        step();
        @(negedge clk);
        chk("lat_m_valid_c5", int'(m_valid), 0);
        drain("drain_single");

        // Throughput: 16 words with m_ready held high, no bubbles.
        for (int i = 0; i < 16; i++) load(DW'(i));
        n_rd = 0; n_v = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rd_en) n_rd++;
            if (m_valid) begin
                n_v++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            step();
        end
        chk("tp_rd_en_cycles", n_rd, 16);
        chk("tp_valid_cycles", n_v, 16);
        chk("tp_valid_span", last_v - first_v + 1, 16);
        chk("tp_first_valid", first_v, 4);
        drain("drain_tp");

        // Back-pressure: only BUFD reads issue while stalled.
        m_ready = 1'b0;
`ifdef FWFT_CNT_EN
        fifo_cnt = 3'd5;
`endif
        for (int i = 0; i < 8; i++) load(DW'(i));
        n_rd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_en) n_rd++;
            if (c == 11) begin
                chk("bp_rd_en_idle", int'(rd_en), 0);
                chk("bp_m_data_head", int'(m_data), 0);
`ifdef FWFT_CNT_EN
                chk("bp_occupancy", int'(occupancy), 10);
`endif
            end
            step();
        end
        chk("bp_reads", n_rd, int'(BUFD));
`ifdef FWFT_CNT_EN
        fifo_cnt = '0;
`endif
        drain("drain_bp");

        // Reset with 2 words buffered and 1 in flight; only post-reset words may appear.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) load(32'h0000_0300 + DW'(i));
        repeat (5) step();
        rst = 1'b1;
        exp_q.delete();
        load(32'h0000_0400);
        load(32'h0000_0401);
        @(negedge clk);
        chk("mid_rst_rd_en", int'(rd_en), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_m_valid", int'(m_valid), 0);
        chk("post_rst_m_data", int'(m_data), 0);
        chk("post_rst_rd_en", int'(rd_en), 1);
        drain("drain_rst");

        // Random back-pressure and empty gaps over 1000 words.
        for (int i = 0; i < 1000; i++) load(32'h1000_0000 + DW'(i * 3));
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20000) begin
                m_ready     = 1'($urandom_range(0, 1));
                force_empty = ($urandom_range(0, 3) == 0);
                step();
                n++;
            end
        end
        chk("rand_done", exp_q.size(), 0);
        drain("drain_rand");
        chk("all_words_read", rd_idx, src_n);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
